iob_uart_master_bridge: RTL and testbench

// - Serial-to-bus bridge: receives 8N1 command frames on rxd, executes them as master transactions on an IOb native bus, answers on txd.
// - The bus-master counterpart of the UART peripheral: it drives the CPU-side valid/address/wdata/wstrb and consumes rdata/ready.
// - Used for host debug, memory preload and boot over the RS-232 link.

---
 rtl/iob_uart_master_bridge_if.sv | 16 +
 rtl/iob_uart_master_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_iob_uart_master_bridge.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_uart_master_bridge_if.sv
// IOb native bus as seen between the UART bridge (bus master) and the target memory/peripheral.
// The address and data widths are parameters so one definition serves every bridge instance.
interface iob_uart_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  m_valid;
   logic [ADDR_W-1:0]     m_address;
   logic [DATA_W-1:0]     m_wdata;
   logic [DATA_W/8-1:0]   m_wstrb;
   logic [DATA_W-1:0]     m_rdata;
   logic                  m_ready;

   modport master (output m_valid, m_address, m_wdata, m_wstrb, input m_rdata, m_ready);
   modport slave  (input m_valid, m_address, m_wdata, m_wstrb, output m_rdata, m_ready);
endinterface

// File: rtl/iob_uart_master_bridge.sv
// UART command bridge: receives 8N1 WRITE/READ frames on rxd, runs them as IOb bus transactions,
// and sends the reply (ACK, NAK or the read data) back on txd.
module iob_uart_master_bridge #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              bit_duration,
   input  logic                     rxd,
   output logic                     txd,
   input  logic                     cts,
   output logic                     rts,
   iob_uart_master_bridge_if.master m_bus
);
   localparam int DATA_B = DATA_W / 8;
   localparam int ADDR_B = (ADDR_W + 7) / 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_BUS  = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   // ---------------- receiver ----------------
   logic        r_rx_s1, r_rx_s2, r_rx_d, r_rx_busy;
   logic [15:0] r_rx_bd, r_rx_cnt;
   logic [3:0]  r_rx_bit;
   logic [7:0]  r_rx_sh;
   logic [15:0] w_rx_tgt;
   logic        w_rx_smp, w_rx_vld, w_rx_ferr;

   // The start bit is checked half a bit after the edge; every later sample is one full bit on.
   assign w_rx_tgt  = (r_rx_bit == 4'd0) ? {1'b0, r_rx_bd[15:1]} : r_rx_bd - 16'd1;
   assign w_rx_smp  = r_rx_busy && (r_rx_cnt == w_rx_tgt);
   assign w_rx_vld  = w_rx_smp && (r_rx_bit == 4'd9) && r_rx_s2;
   assign w_rx_ferr = w_rx_smp && (r_rx_bit == 4'd9) && !r_rx_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_d    <= 1'b1;
         r_rx_busy <= 1'b0;
         r_rx_bd   <= '0;
         r_rx_cnt  <= '0;
         r_rx_bit  <= '0;
         r_rx_sh   <= '0;
      end else begin
         r_rx_s1 <= rxd;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
         if (!r_rx_busy) begin
            if (r_rx_d && !r_rx_s2) begin
               r_rx_busy <= 1'b1;
               r_rx_bd   <= bit_duration;
               r_rx_cnt  <= '0;
               r_rx_bit  <= '0;
            end
         end else if (w_rx_smp) begin
            r_rx_cnt <= '0;
            if (r_rx_bit == 4'd0) begin
               if (r_rx_s2) r_rx_busy <= 1'b0;
               else         r_rx_bit  <= 4'd1;
            end else if (r_rx_bit == 4'd9) begin
               r_rx_busy <= 1'b0;
               r_rx_bit  <= '0;
            end else begin
               r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
               r_rx_bit <= r_rx_bit + 4'd1;
            end
         end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
         end
      end
   end

   // ---------------- command FSM / bus master ----------------
   logic [2:0]          r_state;
   logic                r_wr, r_valid, r_rts;
   logic [3:0]          r_bcnt, r_nleft;
   logic [ADDR_B*8-1:0] r_addr;
   logic [DATA_W-1:0]   r_wdata, r_rbuf;
   logic [DATA_B-1:0]   r_wstrb;

   logic        r_txd, r_tx_busy;
   logic [15:0] r_tx_bd, r_tx_cnt;
   logic [3:0]  r_tx_bit;
   logic [8:0]  r_tx_sh;
   logic        w_tx_start, w_tx_done;

   assign w_tx_start = (r_state == S_RESP) && (r_nleft != 4'd0) && !r_tx_busy && cts;
   assign w_tx_done  = r_tx_busy && (r_tx_cnt == r_tx_bd - 16'd1) && (r_tx_bit == 4'd9);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_wr    <= 1'b0;
         r_valid <= 1'b0;
         r_rts   <= 1'b1;
         r_bcnt  <= '0;
         r_nleft <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rbuf  <= '0;
         r_wstrb <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_rx_vld) begin
               r_bcnt <= '0;
               if (r_rx_sh == 8'h01 || r_rx_sh == 8'h02) begin
                  r_wr    <= (r_rx_sh == 8'h01);
                  r_state <= S_ADDR;
               end else begin
                  r_rbuf  <= DATA_W'(8'h15);
                  r_nleft <= 4'd1;
                  r_state <= S_RESP;
               end
            end
            S_ADDR: if (w_rx_ferr) begin
               r_state <= S_IDLE;
            end else if (w_rx_vld) begin
               r_addr <= {r_rx_sh, r_addr[ADDR_B*8-1:8]};
               r_bcnt <= r_bcnt + 4'd1;
               if (r_bcnt == 4'(ADDR_B - 1)) begin
                  r_bcnt <= '0;
                  if (r_wr) begin
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_BUS;
                     r_valid <= 1'b1;
                     r_wstrb <= '0;
                     r_rts   <= 1'b0;
                  end
               end
            end
            S_DATA: if (w_rx_ferr) begin
               r_state <= S_IDLE;
            end else if (w_rx_vld) begin
               r_wdata <= {r_rx_sh, r_wdata[DATA_W-1:8]};
               r_bcnt  <= r_bcnt + 4'd1;
               if (r_bcnt == 4'(DATA_B - 1)) begin
                  r_bcnt  <= '0;
                  r_state <= S_BUS;
                  r_valid <= 1'b1;
                  r_wstrb <= '1;
                  r_rts   <= 1'b0;
               end
            end
            S_BUS: if (r_valid && m_bus.m_ready) begin
               r_valid <= 1'b0;
               r_rbuf  <= r_wr ? DATA_W'(8'h06) : m_bus.m_rdata;
               r_nleft <= r_wr ? 4'd1 : 4'(DATA_B);
               r_state <= S_RESP;
            end
            S_RESP: begin
               // Reply bytes leave LSB first; IDLE only once the final stop bit is fully out.
               if (w_tx_start) begin
                  r_rbuf  <= r_rbuf >> 8;
                  r_nleft <= r_nleft - 4'd1;
               end
               if (w_tx_done && r_nleft == 4'd0) begin
                  r_state <= S_IDLE;
                  r_rts   <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_txd     <= 1'b1;
         r_tx_busy <= 1'b0;
         r_tx_bd   <= '0;
         r_tx_cnt  <= '0;
         r_tx_bit  <= '0;
         r_tx_sh   <= '1;
      end else if (w_tx_start) begin
         r_tx_busy <= 1'b1;
         r_txd     <= 1'b0;
         r_tx_sh   <= {1'b1, r_rbuf[7:0]};
         r_tx_bd   <= bit_duration;
         r_tx_cnt  <= '0;
         r_tx_bit  <= '0;
      end else if (r_tx_busy) begin
         if (r_tx_cnt == r_tx_bd - 16'd1) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 4'd9) begin
               r_tx_busy <= 1'b0;
               r_txd     <= 1'b1;
               r_tx_bit  <= '0;
            end else begin
               r_txd    <= r_tx_sh[0];
               r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
               r_tx_bit <= r_tx_bit + 4'd1;
            end
         end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
         end
      end
   end

   assign txd              = r_txd;
   assign rts              = r_rts;
   assign m_bus.m_valid    = r_valid;
   assign m_bus.m_address  = r_addr[ADDR_W-1:0];
   assign m_bus.m_wdata    = r_wdata;
   assign m_bus.m_wstrb    = r_wstrb;
endmodule

// File: tb/tb_iob_uart_master_bridge.sv
// Directed bench for the UART bus bridge: serial frames in, bus transactions and serial replies checked.
// A negedge-driven bus target answers requests after a programmable number of wait cycles.
module tb_iob_uart_master_bridge;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] bit_duration;
   logic        rxd, txd, cts, rts;

   iob_uart_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   iob_uart_master_bridge #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .bit_duration(bit_duration), .rxd(rxd), .txd(txd),
      .cts(cts), .rts(rts), .m_bus(bus.master)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_err = 0;
   int          resp_wait = 0;
   logic        resp_hold = 1'b0;
   logic [31:0] bus_rdata = '0;
   int          resp_ctr = 0, vld_rises = 0;
   logic        vld_q = 1'b0;
   logic [31:0] cap_addr = '0, cap_wdata = '0;
   logic [3:0]  cap_wstrb = '0;

   // Bus target: counts request rises, answers with a one-cycle m_ready after resp_wait cycles.
   always @(negedge clk) begin
      if (bus.m_valid === 1'b1 && !vld_q) vld_rises++;
      vld_q = (bus.m_valid === 1'b1);
      if (bus.m_valid === 1'b1 && !resp_hold && bus.m_ready !== 1'b1) begin
         if (resp_ctr >= resp_wait) begin
            bus.m_ready = 1'b1;
            bus.m_rdata = bus_rdata;
            cap_addr    = bus.m_address;
            cap_wdata   = bus.m_wdata;
            cap_wstrb   = bus.m_wstrb;
            resp_ctr    = 0;
         end else begin
            resp_ctr++;
            bus.m_ready = 1'b0;
         end
      end else begin
         bus.m_ready = 1'b0;
         bus.m_rdata = '0;
         if (bus.m_valid !== 1'b1) resp_ctr = 0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(16);
      end
      rxd = stop;
      tick(16);
      rxd = 1'b1;
   endtask

   // Bytes go out lowest-order byte of the vector first.
   task automatic send_frame(input logic [71:0] bytes, input int n);
      for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8], 1'b1);
   endtask

   // Returns after sampling the stop bit at its middle.
   task automatic recv_byte(output logic [7:0] b, output logic ok);
      int t = 0;
      ok = 1'b1;
      b  = '0;
      while (txd !== 1'b0 && t < 6000) begin
         tick(1);
         t++;
      end
      if (t >= 6000) begin
         ok = 1'b0;
         return;
      end
      tick(8);
      if (txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(16);
         b[i] = txd;
      end
      tick(16);
      if (txd !== 1'b1) ok = 1'b0;
   endtask

   logic [7:0] rb[4];
   logic       rok[4];
   int         base, lows, t;

   initial begin
      rst = 1'b0; rxd = 1'b1; cts = 1'b1; bit_duration = 16'd16;
      tick(3);
      chk("rst_txd", txd, 1);
      chk("rst_rts", rts, 1);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_addr", bus.m_address, 0);
      chk("rst_wdata", bus.m_wdata, 0);
      chk("rst_wstrb", bus.m_wstrb, 0);
      rst = 1'b1;
      tick(5);

      // WRITE 0xDEADBEEF to 0x10
      resp_wait = 2;
      base = vld_rises;
      fork
         send_frame(72'hDE_AD_BE_EF_00_00_00_10_01, 9);
         recv_byte(rb[0], rok[0]);
      join
      chk("wr_ok", rok[0], 1);
      chk("wr_ack", rb[0], 8'h06);
      chk("wr_addr", cap_addr, 32'h10);
      chk("wr_data", cap_wdata, 32'hDEADBEEF);
      chk("wr_strb", cap_wstrb, 4'hF);
      chk("wr_rises", vld_rises - base, 1);
      tick(12);
      chk("wr_rts_back", rts, 1);

      // READ from 0x20 with 5 wait cycles
      resp_wait = 5;
      bus_rdata = 32'h12345678;
      fork
         send_frame(72'h00_00_00_00_20_02, 5);
         for (int i = 0; i < 4; i++) recv_byte(rb[i], rok[i]);
      join
      chk("rd_ok", rok[0] & rok[1] & rok[2] & rok[3], 1);
      chk("rd_bytes", {rb[3], rb[2], rb[1], rb[0]}, 32'h12345678);
      chk("rd_addr", cap_addr, 32'h20);
      chk("rd_strb", cap_wstrb, 4'h0);
      chk("rd_rts_low_in_stop", rts, 0);
      tick(12);
      chk("rd_rts_back", rts, 1);

      // Unknown command -> NAK, no bus access; then a normal READ
      base = vld_rises;
      fork
         send_frame(72'h7E, 1);
         recv_byte(rb[0], rok[0]);
      join
      chk("nak_ok", rok[0], 1);
      chk("nak_byte", rb[0], 8'h15);
      chk("nak_no_bus", vld_rises - base, 0);
      bus_rdata = 32'hA5A50F0F;
      fork
         send_frame(72'h00_00_00_00_00_02, 5);
         for (int i = 0; i < 4; i++) recv_byte(rb[i], rok[i]);
      join
      chk("post_nak_ok", rok[0] & rok[1] & rok[2] & rok[3], 1);
      chk("post_nak_bytes", {rb[3], rb[2], rb[1], rb[0]}, 32'hA5A50F0F);
      chk("post_nak_addr", cap_addr, 32'h0);
      tick(20);

      // Framing error in the address byte drops the command
      base = vld_rises;
      send_byte(8'h02, 1'b1);
      send_byte(8'h33, 1'b0);
      tick(40);
      chk("ferr_no_bus", vld_rises - base, 0);
      resp_wait = 1;
      fork
         send_frame(72'h44_33_22_11_00_00_00_44_01, 9);
         recv_byte(rb[0], rok[0]);
      join
      chk("ferr_wr_ack", rb[0], 8'h06);
      chk("ferr_wr_addr", cap_addr, 32'h44);
      chk("ferr_wr_data", cap_wdata, 32'h44332211);
      chk("ferr_wr_rises", vld_rises - base, 1);
      tick(20);

      // cts held low after the first reply byte
      bus_rdata = 32'hCAFEF00D;
      fork
         send_frame(72'h00_00_00_30_02, 5);
         begin
            recv_byte(rb[0], rok[0]);
            cts = 1'b0;
         end
      join
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (txd !== 1'b1) lows++;
      end
      chk("cts_hold_idle", lows, 0);
      cts = 1'b1;
      for (int i = 1; i < 4; i++) recv_byte(rb[i], rok[i]);
      chk("cts_ok", rok[0] & rok[1] & rok[2] & rok[3], 1);
      chk("cts_bytes", {rb[3], rb[2], rb[1], rb[0]}, 32'hCAFEF00D);
      tick(20);

      // Reset while a bus request is pending
      resp_hold = 1'b1;
      send_frame(72'h00_00_00_40_02, 5);
      t = 0;
      while (bus.m_valid !== 1'b1 && t < 200) begin
         tick(1);
         t++;
      end
      chk("rstbus_valid_seen", bus.m_valid, 1);
      chk("rstbus_rts_low", rts, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("rstbus_valid", bus.m_valid, 0);
      chk("rstbus_txd", txd, 1);
      chk("rstbus_rts", rts, 1);
      chk("rstbus_addr", bus.m_address, 0);
      tick(3);
      rst = 1'b1;
      resp_hold = 1'b0;
      base = vld_rises;
      lows = 0;
      for (int i = 0; i < 400; i++) begin
         tick(1);
         if (txd !== 1'b1) lows++;
      end
      chk("rstbus_no_reply", lows, 0);
      chk("rstbus_no_bus", vld_rises - base, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
